// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : owns the program counter, fetches from Instruction_Mem into a
//              2-entry IF/ID buffer, handles redirects and halts on ECALL.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  output logic        imem_pc_en,
  output logic        imem_flush,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_pc_q, head_pc_d, head_instr_q, head_instr_d;
  logic [31:0] tail_pc_q, tail_pc_d, tail_instr_q, tail_instr_d;

  logic        pop;
  logic        push;
  logic [1:0]  count_after_pop;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign pop        = (count_q != 2'd0) & id_ready & ~redirect_valid;
  assign imem_pc_en = (state_q == S_RUN) & ~redirect_valid & ((count_q != 2'd2) | pop);
  assign push       = imem_pc_en;
  assign imem_flush = redirect_valid & (state_q != S_BOOT);
  assign imem_pc    = pc_q;

  assign id_valid = (count_q != 2'd0);
  assign id_instr = id_valid ? head_instr_q : 32'd0;
  assign id_pc    = id_valid ? head_pc_q    : 32'd0;
  assign halted   = (state_q == S_HALT);

  assign count_after_pop = count_q - {1'b0, pop};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;

    if (redirect_valid) begin
      // Redirect wins over everything: drop the buffer and restart at the target.
      count_d = 2'd0;
      pc_d    = {redirect_pc[31:2], 2'b00};
      state_d = S_RUN;
    end else begin
      if (pop) begin
        head_pc_d    = tail_pc_q;
        head_instr_d = tail_instr_q;
      end
      if (push) begin
        if (count_after_pop == 2'd0) begin
          head_pc_d    = pc_q;
          head_instr_d = imem_instr;
        end else begin
          tail_pc_d    = pc_q;
          tail_instr_d = imem_instr;
        end
        pc_d = pc_q + 32'd4;
        if (imem_instr == HALT_INSTR) begin
          state_d = S_HALT;
        end
      end
      count_d = count_after_pop + {1'b0, push};
      if (state_q == S_BOOT) begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      count_q      <= 2'd0;
      head_pc_q    <= 32'd0;
      head_instr_q <= 32'd0;
      tail_pc_q    <= 32'd0;
      tail_instr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : randomized and directed bench for fetch_unit against a
//                 queue-based reference model.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic        imem_pc_en;
  logic        imem_flush;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .HALT_INSTR(HALT_INSTR)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_pc(imem_pc), .imem_pc_en(imem_pc_en), .imem_flush(imem_flush),
    .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .halted(halted)
  );

  // Instruction memory contents: fixed words at 0, 4 and the ECALL at 0x190.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] h;
    case (addr)
      32'h0000_0000: return 32'h01E5_0533;
      32'h0000_0004: return 32'h00B6_0693;
      32'h0000_0190: return HALT_INSTR;
      default: begin
        h = (addr * 32'h9E37_79B1) ^ 32'h5A5A_0013;
        if (h == HALT_INSTR) h = h ^ 32'h1;
        return h;
      end
    endcase
  endfunction

  assign imem_instr = imem_flush ? 32'd0 : mem_word(imem_pc);

  // Reference model: pc, fetch state (0 boot, 1 run, 2 halt), queue of {pc,instr}
  logic [31:0] m_pc;
  int          m_state;
  logic [63:0] m_q[$];
  logic        m_pop, m_fetch;
  logic [99:0] exp_v, act_v;

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_state = 0;
    m_q.delete();
  endtask

  // Apply inputs for this cycle and compute the outputs the model expects.
  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rp);
    logic        e_valid;
    logic [31:0] e_instr, e_idpc;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    #2;
    e_valid = (m_q.size() != 0);
    e_idpc  = e_valid ? m_q[0][63:32] : 32'd0;
    e_instr = e_valid ? m_q[0][31:0]  : 32'd0;
    m_pop   = e_valid && rdy && !rv;
    m_fetch = (m_state == 1) && !rv && ((m_q.size() < 2) || m_pop);
    exp_v = {m_pc, m_fetch, (rv && m_state != 0), e_valid, e_instr, e_idpc, (m_state == 2)};
    act_v = {imem_pc, imem_pc_en, imem_flush, id_valid, id_instr, id_pc, halted};
  endtask

  task automatic advance();
    logic [31:0] w;
    if (redirect_valid) begin
      m_q.delete();
      m_pc    = redirect_pc & ~32'h3;
      m_state = 1;
    end else begin
      if (m_pop) void'(m_q.pop_front());
      if (m_fetch) begin
        w = mem_word(m_pc);
        m_q.push_back({m_pc, w});
        if (w == HALT_INSTR) m_state = 2;
        m_pc = m_pc + 32'd4;
      end else if (m_state == 0) begin
        m_state = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({imem_pc, imem_pc_en, imem_flush, id_valid, id_instr, id_pc, halted} !==
        {RESET_PC, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset got pc=%h en=%b fl=%b v=%b ins=%h idpc=%h h=%b required all zero",
               imem_pc, imem_pc_en, imem_flush, id_valid, id_instr, id_pc, halted);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL stream cyc %0d got %h required %h", i, act_v, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 12; i++) begin
      drive(i >= 5, 1'b0, 32'd0);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL backpressure cyc %0d got %h required %h", i, act_v, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'd0);
      advance();
    end
    drive(1'b1, 1'b1, 32'h0000_0053);
    checks++;
    if ({imem_flush, imem_pc_en, id_valid} !== 3'b101) begin
      errors++;
      $display("FAIL redirect_cycle got fl/en/v=%b%b%b required 101", imem_flush, imem_pc_en, id_valid);
    end
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL redirect_model got %h required %h", act_v, exp_v);
    end
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      if (i == 0) begin
        checks++;
        if ({id_valid, imem_pc} !== {1'b0, 32'h0000_0050}) begin
          errors++;
          $display("FAIL redirect_target got v=%b pc=%h required v=0 pc=00000050", id_valid, imem_pc);
        end
      end
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL redirect_after cyc %0d got %h required %h", i, act_v, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, i == 0, 32'h0000_0180);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL halt cyc %0d got %h required %h", i, act_v, exp_v);
      end
      advance();
    end
    drive(1'b1, 1'b0, 32'd0);
    checks++;
    if ({halted, id_valid, imem_pc_en, imem_pc} !== {1'b1, 1'b0, 1'b0, 32'h0000_0194}) begin
      errors++;
      $display("FAIL halt_drained got h=%b v=%b en=%b pc=%h required 1 0 0 00000194",
               halted, id_valid, imem_pc_en, imem_pc);
    end
    advance();
    drive(1'b1, 1'b1, 32'h0000_0000);
    advance();
    drive(1'b1, 1'b0, 32'd0);
    checks++;
    if ({halted, imem_pc_en, imem_pc} !== {1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL halt_resume got h=%b en=%b pc=%h required 0 1 00000000", halted, imem_pc_en, imem_pc);
    end
    advance();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, i == 0, 32'hFFFF_FFFA);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL wrap cyc %0d got %h required %h", i, act_v, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    for (int i = 0; i < 400; i++) begin
      tgt = ($urandom % 3 == 0) ? 32'h0000_0170 + ($urandom % 16) : $urandom;
      drive(($urandom % 4) != 0, ($urandom % 12) == 0, tgt);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL random cyc %0d got %h required %h", i, act_v, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 1'b1, 32'h0000_0200);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'd0);
      advance();
    end
    drive(1'b0, 1'b0, 32'd0);
    checks++;
    if ({id_valid, imem_pc_en} !== 2'b10) begin
      errors++;
      $display("FAIL midreset_full got v=%b en=%b required v=1 en=0", id_valid, imem_pc_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_pc, imem_pc_en, imem_flush, id_valid, id_instr, id_pc, halted} !==
        {RESET_PC, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_async got pc=%h en=%b v=%b ins=%h idpc=%h required reset values",
               imem_pc, imem_pc_en, id_valid, id_instr, id_pc);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL midreset_resume cyc %0d got %h required %h", i, act_v, exp_v);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
